destination_register_mux: RTL and testbench

Destination-register selector for the MIPS datapath: picks the register-file write address between the instruction's rt field and rd field under the RegDst control, with an optional forced link address ($31) for jal-type writes. The combinational result feeds the register file write port in the single-cycle path; a registered copy with write-enable qualification, stall and flush is provided for pipelined or multi-cycle use of the same block.

---
 rtl/destination_register_mux.sv | 54 +++++
 tb/tb_destination_register_mux.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/destination_register_mux.sv
// Destination-register selector: picks rt, rd or the link register as the
// register-file write address, with a registered copy that can be stalled
// or flushed and a write enable that drops writes aimed at register 0.
module destination_register_mux #(
    parameter int unsigned ADDR_W = 5,
    parameter logic [ADDR_W-1:0] LINK_REG = ADDR_W'(31)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] in1,
    input  logic [ADDR_W-1:0] in2,
    input  logic              select,
    input  logic              link,
    input  logic              reg_write_in,
    input  logic              stall,
    input  logic              flush,
    output logic [ADDR_W-1:0] out,
    output logic [ADDR_W-1:0] out_q,
    output logic              reg_write_q,
    output logic              dest_zero
);

    logic [ADDR_W-1:0] dest;
    logic              we_next;

    // Destination choice: link overrides RegDst, RegDst picks rd over rt
    always_comb begin
        dest = in1;
        if (link) begin
            dest = LINK_REG;
        end else if (select) begin
            dest = in2;
        end
    end

    assign out       = dest;
    assign dest_zero = (dest == '0);
    assign we_next   = reg_write_in & ~dest_zero;

    // Pipeline copy: flush inserts a bubble and beats stall, stall holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            reg_write_q <= 1'b0;
        end else if (flush) begin
            out_q       <= '0;
            reg_write_q <= 1'b0;
        end else if (!stall) begin
            out_q       <= dest;
            reg_write_q <= we_next;
        end
    end

endmodule

// File: tb/tb_destination_register_mux.sv
// Self-checking bench for destination_register_mux: combinational outputs
// checked directly, registered outputs checked through a scoreboard queue.
module tb_destination_register_mux;

    localparam int unsigned ADDR_W = 5;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] in1;
    logic [ADDR_W-1:0] in2;
    logic              select;
    logic              link;
    logic              reg_write_in;
    logic              stall;
    logic              flush;
    logic [ADDR_W-1:0] out;
    logic [ADDR_W-1:0] out_q;
    logic              reg_write_q;
    logic              dest_zero;

    typedef struct {
        logic [ADDR_W-1:0] q;
        logic              we;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    logic [ADDR_W-1:0] m_q;
    logic              m_we;

    destination_register_mux #(
        .ADDR_W   (ADDR_W),
        .LINK_REG (5'd31)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in1          (in1),
        .in2          (in2),
        .select       (select),
        .link         (link),
        .reg_write_in (reg_write_in),
        .stall        (stall),
        .flush        (flush),
        .out          (out),
        .out_q        (out_q),
        .reg_write_q  (reg_write_q),
        .dest_zero    (dest_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // One cycle: drive, check combinational result, push expected register, clock, pop and compare
    task automatic drive_cycle(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                               input logic s, input logic l, input logic rw,
                               input logic st, input logic fl);
        logic [ADDR_W-1:0] e_out;
        exp_t              e;
        in1 = a; in2 = b; select = s; link = l;
        reg_write_in = rw; stall = st; flush = fl;
        e_out = l ? 5'd31 : (s ? b : a);
        #1;
        check("out", 32'(out), 32'(e_out));
        check("dest_zero", 32'(dest_zero), 32'(e_out == 5'd0));
        if (fl) begin
            m_q = '0; m_we = 1'b0;
        end else if (!st) begin
            m_q = e_out; m_we = rw && (e_out != 5'd0);
        end
        e.q = m_q; e.we = m_we;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("out_q", 32'(out_q), 32'(e.q));
            check("reg_write_q", 32'(reg_write_q), 32'(e.we));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        in1 = 5'd5; in2 = 5'd9; select = 1'b0; link = 1'b0;
        reg_write_in = 1'b1; stall = 1'b0; flush = 1'b0;
        m_q = '0; m_we = 1'b0;
        #1;
        check("rst_out_q", 32'(out_q), 32'd0);
        check("rst_we", 32'(reg_write_q), 32'd0);
        check("rst_out_follows", 32'(out), 32'd5);
        @(posedge clk);
        #1;
        check("rst_hold_out_q", 32'(out_q), 32'd0);
        #3 rst_n = 1'b1;

        // rt selected, then rd without needing an edge for out
        drive_cycle(5'b01010, 5'b11111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive_cycle(5'b01010, 5'b11111, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        // link overrides select both ways
        drive_cycle(5'b00011, 5'b00100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        drive_cycle(5'b00011, 5'b00100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        // write to $0 is disqualified
        drive_cycle(5'b00000, 5'b11111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        // load 01010, stall while select flips, then flush beats stall
        drive_cycle(5'b01010, 5'b11111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive_cycle(5'b01010, 5'b11111, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        drive_cycle(5'b01010, 5'b11111, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        // load 11111 then assert reset between edges
        drive_cycle(5'b01010, 5'b11111, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_out_q", 32'(out_q), 32'd0);
        check("async_rst_we", 32'(reg_write_q), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("rst_held_out_q", 32'(out_q), 32'd0);
            check("rst_held_we", 32'(reg_write_q), 32'd0);
        end
        #2 rst_n = 1'b1;
        m_q = '0; m_we = 1'b0;
        drive_cycle(5'b00111, 5'b11000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Random mix of selects, stalls and flushes
        for (int i = 0; i < 60; i++) begin
            drive_cycle(ADDR_W'($urandom_range(0, 31)), ADDR_W'($urandom_range(0, 31)),
                        1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
                        1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                        ($urandom_range(0, 7) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
